// File: rtl/control_and_status_register_file_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, trap causes,
// status/enable bit positions and the CSR read-modify-write op encoding.
package csr_definitions;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   localparam logic [31:0] MCAUSE_ECALL_M         = 32'd11;
   localparam logic [31:0] MCAUSE_MACHINE_TIMER   = 32'h8000_0007;

   localparam int unsigned MSTATUS_MIE_BIT  = 3;
   localparam int unsigned MSTATUS_MPIE_BIT = 7;
   localparam int unsigned MIE_MTIE_BIT     = 7;
   localparam int unsigned MIP_MTIP_BIT     = 7;

   typedef enum logic [1:0] {
      CSR_OP_NONE  = 2'b00,
      CSR_OP_WRITE = 2'b01,
      CSR_OP_SET   = 2'b10,
      CSR_OP_CLEAR = 2'b11
   } csr_op_e;

   function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                                input logic [31:0] old_value,
                                                input logic [31:0] operand);
      case (op)
         CSR_OP_WRITE: return operand;
         CSR_OP_SET:   return old_value | operand;
         CSR_OP_CLEAR: return old_value & ~operand;
         default:      return old_value;
      endcase
   endfunction

endpackage

// File: rtl/control_and_status_register_file_csr_counter_64.sv
// 64-bit free-running counter whose halves can each be overwritten; a write
// to either half takes the place of that cycle's increment.
module csr_counter_64 (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_increment,
   input  logic        i_write_low,
   input  logic        i_write_high,
   input  logic [31:0] i_write_data,
   output logic [63:0] o_value
);

   logic [63:0] r_value;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_value <= '0;
      end else if (i_write_low) begin
         r_value[31:0] <= i_write_data;
      end else if (i_write_high) begin
         r_value[63:32] <= i_write_data;
      end else if (i_increment) begin
         r_value <= r_value + 64'd1;
      end
   end

   assign o_value = r_value;

endmodule

// File: rtl/control_and_status_register_file.sv
// Machine-mode CSR file with trap/return sequencing for ECALL, MRET and the
// machine timer interrupt, plus 64-bit cycle and retired-instruction counters.
module control_and_status_register_file
   import csr_definitions::*;
#(
   parameter logic [31:0] HART_ID           = 32'd0,
   parameter logic [31:0] RESET_TRAP_VECTOR = 32'h0000_0100
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        instruction_valid,
   input  logic        csr_write_enable,
   input  logic        is_environment_call,
   input  logic        is_machine_return,
   input  logic [2:0]  function_3,
   input  logic [11:0] csr_address,
   input  logic [31:0] csr_write_operand,
   input  logic [31:0] program_counter,
   input  logic        instruction_retired,
   input  logic        timer_interrupt_pending,
   output logic [31:0] csr_read_data,
   output logic        trap_taken,
   output logic [31:0] trap_target_pc,
   output logic        return_taken,
   output logic [31:0] return_target_pc
);

   logic        r_mie;
   logic        r_mpie;
   logic        r_mtie;
   logic [31:2] r_mtvec;
   logic [31:0] r_mscratch;
   logic [31:2] r_mepc;
   logic [31:0] r_mcause;

   logic [63:0] w_mcycle;
   logic [63:0] w_minstret;
   logic [31:0] w_mstatus_view;
   logic [31:0] w_mie_view;
   logic [31:0] w_mip_view;
   logic [31:0] w_read_data;
   logic [31:0] w_new_value;
   logic        w_interrupt;
   logic        w_ecall;
   logic        w_mret;
   logic        w_csr_write;
   logic        w_unused_bits;

   // Priority chain: each lower-priority event is masked by every one above it.
   assign w_interrupt = instruction_valid & r_mie & r_mtie & timer_interrupt_pending;
   assign w_ecall     = instruction_valid & is_environment_call & ~w_interrupt;
   assign w_mret      = instruction_valid & is_machine_return & ~w_interrupt & ~w_ecall;
   assign w_csr_write = instruction_valid & csr_write_enable & ~w_interrupt & ~w_ecall
                        & ~w_mret & (function_3[1:0] != CSR_OP_NONE);

   assign trap_taken       = ~reset & (w_interrupt | w_ecall);
   assign return_taken     = ~reset & w_mret;
   assign trap_target_pc   = {r_mtvec, 2'b00};
   assign return_target_pc = {r_mepc, 2'b00};

   assign w_unused_bits = ^{function_3[2], program_counter[1:0]};

   always_comb begin
      w_mstatus_view                   = '0;
      w_mstatus_view[12:11]            = 2'b11;
      w_mstatus_view[MSTATUS_MIE_BIT]  = r_mie;
      w_mstatus_view[MSTATUS_MPIE_BIT] = r_mpie;
      w_mie_view                       = '0;
      w_mie_view[MIE_MTIE_BIT]         = r_mtie;
      w_mip_view                       = '0;
      w_mip_view[MIP_MTIP_BIT]         = timer_interrupt_pending;
   end

   always_comb begin
      case (csr_address)
         CSR_MSTATUS:                w_read_data = w_mstatus_view;
         CSR_MIE:                    w_read_data = w_mie_view;
         CSR_MTVEC:                  w_read_data = {r_mtvec, 2'b00};
         CSR_MSCRATCH:               w_read_data = r_mscratch;
         CSR_MEPC:                   w_read_data = {r_mepc, 2'b00};
         CSR_MCAUSE:                 w_read_data = r_mcause;
         CSR_MIP:                    w_read_data = w_mip_view;
         CSR_MCYCLE,   CSR_CYCLE:    w_read_data = w_mcycle[31:0];
         CSR_MCYCLEH,  CSR_CYCLEH:   w_read_data = w_mcycle[63:32];
         CSR_MINSTRET, CSR_INSTRET:  w_read_data = w_minstret[31:0];
         CSR_MINSTRETH, CSR_INSTRETH: w_read_data = w_minstret[63:32];
         CSR_MHARTID:                w_read_data = HART_ID;
         default:                    w_read_data = '0;
      endcase
   end

   assign csr_read_data = w_read_data;
   assign w_new_value   = csr_apply_op(csr_op_e'(function_3[1:0]), w_read_data, csr_write_operand);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_mie      <= 1'b0;
         r_mpie     <= 1'b0;
         r_mtie     <= 1'b0;
         r_mtvec    <= RESET_TRAP_VECTOR[31:2];
         r_mscratch <= '0;
         r_mepc     <= '0;
         r_mcause   <= '0;
      end else if (w_interrupt || w_ecall) begin
         r_mepc   <= program_counter[31:2];
         r_mcause <= w_interrupt ? MCAUSE_MACHINE_TIMER : MCAUSE_ECALL_M;
         r_mpie   <= r_mie;
         r_mie    <= 1'b0;
      end else if (w_mret) begin
         r_mie  <= r_mpie;
         r_mpie <= 1'b1;
      end else if (w_csr_write) begin
         case (csr_address)
            CSR_MSTATUS: begin
               r_mie  <= w_new_value[MSTATUS_MIE_BIT];
               r_mpie <= w_new_value[MSTATUS_MPIE_BIT];
            end
            CSR_MIE:      r_mtie     <= w_new_value[MIE_MTIE_BIT];
            CSR_MTVEC:    r_mtvec    <= w_new_value[31:2];
            CSR_MSCRATCH: r_mscratch <= w_new_value;
            CSR_MEPC:     r_mepc     <= w_new_value[31:2];
            CSR_MCAUSE:   r_mcause   <= w_new_value;
            default: ;
         endcase
      end
   end

   csr_counter_64 u_mcycle (
      .clock        (clock),
      .reset        (reset),
      .i_increment  (1'b1),
      .i_write_low  (w_csr_write && (csr_address == CSR_MCYCLE)),
      .i_write_high (w_csr_write && (csr_address == CSR_MCYCLEH)),
      .i_write_data (w_new_value),
      .o_value      (w_mcycle)
   );

   csr_counter_64 u_minstret (
      .clock        (clock),
      .reset        (reset),
      .i_increment  (instruction_retired),
      .i_write_low  (w_csr_write && (csr_address == CSR_MINSTRET)),
      .i_write_high (w_csr_write && (csr_address == CSR_MINSTRETH)),
      .i_write_data (w_new_value),
      .o_value      (w_minstret)
   );

endmodule

// File: tb/tb_control_and_status_register_file.sv
// Directed bench for the CSR file: reset values, read-modify-write ops,
// ECALL/MRET/timer trap sequencing and 64-bit counter carry and override.
module tb_control_and_status_register_file;

   logic        clock = 1'b0;
   logic        reset;
   logic        instruction_valid;
   logic        csr_write_enable;
   logic        is_environment_call;
   logic        is_machine_return;
   logic [2:0]  function_3;
   logic [11:0] csr_address;
   logic [31:0] csr_write_operand;
   logic [31:0] program_counter;
   logic        instruction_retired;
   logic        timer_interrupt_pending;
   logic [31:0] csr_read_data;
   logic        trap_taken;
   logic [31:0] trap_target_pc;
   logic        return_taken;
   logic [31:0] return_target_pc;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clock = ~clock;

   control_and_status_register_file #(
      .HART_ID           (32'd0),
      .RESET_TRAP_VECTOR (32'h0000_0100)
   ) dut (
      .clock                   (clock),
      .reset                   (reset),
      .instruction_valid       (instruction_valid),
      .csr_write_enable        (csr_write_enable),
      .is_environment_call     (is_environment_call),
      .is_machine_return       (is_machine_return),
      .function_3              (function_3),
      .csr_address             (csr_address),
      .csr_write_operand       (csr_write_operand),
      .program_counter         (program_counter),
      .instruction_retired     (instruction_retired),
      .timer_interrupt_pending (timer_interrupt_pending),
      .csr_read_data           (csr_read_data),
      .trap_taken              (trap_taken),
      .trap_target_pc          (trap_target_pc),
      .return_taken            (return_taken),
      .return_target_pc        (return_target_pc)
   );

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      instruction_valid   = 1'b0;
      csr_write_enable    = 1'b0;
      is_environment_call = 1'b0;
      is_machine_return   = 1'b0;
      function_3          = 3'b000;
      csr_write_operand   = '0;
      instruction_retired = 1'b0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic read_csr(input string tag, input logic [11:0] addr, input logic [31:0] exp);
      csr_address = addr;
      #1;
      check_value(tag, csr_read_data, exp);
   endtask

   task automatic csr_op(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] operand);
      instruction_valid = 1'b1;
      csr_write_enable  = 1'b1;
      function_3        = f3;
      csr_address       = addr;
      csr_write_operand = operand;
      step();
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset                   = 1'b1;
      csr_address             = '0;
      program_counter         = '0;
      timer_interrupt_pending = 1'b0;

      // Trap/return requests are gated while reset is asserted.
      step();
      instruction_valid   = 1'b1;
      is_environment_call = 1'b1;
      #1;
      check_value("trap_in_reset", {31'd0, trap_taken}, 32'd0);
      is_environment_call = 1'b0;
      is_machine_return   = 1'b1;
      #1;
      check_value("ret_in_reset", {31'd0, return_taken}, 32'd0);
      idle_inputs();
      step();
      reset = 1'b0;

      read_csr("rst_mtvec",    12'h305, 32'h0000_0100);
      read_csr("rst_mstatus",  12'h300, 32'h0000_1800);
      read_csr("rst_mhartid",  12'hF14, 32'h0000_0000);
      read_csr("rst_mscratch", 12'h340, 32'h0000_0000);
      read_csr("rst_mcause",   12'h342, 32'h0000_0000);

      // CSRRW / CSRRS / CSRRC on mscratch, checking the old value each time.
      read_csr("rw_old", 12'h340, 32'h0);
      csr_op(3'b001, 12'h340, 32'hDEAD_BEEF);
      read_csr("rs_old", 12'h340, 32'hDEAD_BEEF);
      csr_op(3'b010, 12'h340, 32'h0000_0010);
      read_csr("rc_old", 12'h340, 32'hDEAD_BEFF);
      csr_op(3'b011, 12'h340, 32'h0000_000F);
      read_csr("rc_final", 12'h340, 32'hDEAD_BEF0);

      csr_op(3'b100, 12'h340, 32'h1111_1111);
      read_csr("op00_ignored", 12'h340, 32'hDEAD_BEF0);
      csr_op(3'b001, 12'h7C0, 32'h1234_5678);
      read_csr("unimpl_read0", 12'h7C0, 32'h0);
      csr_write_enable  = 1'b1;
      function_3        = 3'b001;
      csr_address       = 12'h340;
      csr_write_operand = 32'h0BAD_0BAD;
      step();
      idle_inputs();
      read_csr("invalid_ignored", 12'h340, 32'hDEAD_BEF0);

      // ECALL with MIE set.
      csr_op(3'b010, 12'h300, 32'h0000_0008);
      read_csr("mie_set", 12'h300, 32'h0000_1808);
      instruction_valid   = 1'b1;
      is_environment_call = 1'b1;
      program_counter     = 32'h0000_2004;
      #1;
      check_value("ecall_trap", {31'd0, trap_taken}, 32'd1);
      check_value("ecall_target", trap_target_pc, 32'h0000_0100);
      check_value("ecall_noret", {31'd0, return_taken}, 32'd0);
      step();
      idle_inputs();
      read_csr("ecall_mepc",    12'h341, 32'h0000_2004);
      read_csr("ecall_mcause",  12'h342, 32'd11);
      read_csr("ecall_mstatus", 12'h300, 32'h0000_1880);

      // MRET restores MIE from MPIE.
      instruction_valid = 1'b1;
      is_machine_return = 1'b1;
      #1;
      check_value("mret_taken", {31'd0, return_taken}, 32'd1);
      check_value("mret_target", return_target_pc, 32'h0000_2004);
      check_value("mret_notrap", {31'd0, trap_taken}, 32'd0);
      step();
      idle_inputs();
      read_csr("mret_mstatus", 12'h300, 32'h0000_1888);

      // Timer interrupt beats a same-cycle CSRRW to mscratch.
      csr_op(3'b001, 12'h304, 32'h0000_0080);
      read_csr("mie_mtie", 12'h304, 32'h0000_0080);
      timer_interrupt_pending = 1'b1;
      read_csr("mip_mtip", 12'h344, 32'h0000_0080);
      instruction_valid = 1'b1;
      csr_write_enable  = 1'b1;
      function_3        = 3'b001;
      csr_address       = 12'h340;
      csr_write_operand = 32'h1234_5678;
      program_counter   = 32'h0000_3000;
      #1;
      check_value("irq_trap", {31'd0, trap_taken}, 32'd1);
      step();
      idle_inputs();
      timer_interrupt_pending = 1'b0;
      read_csr("irq_mscratch", 12'h340, 32'hDEAD_BEF0);
      read_csr("irq_mcause",   12'h342, 32'h8000_0007);
      read_csr("irq_mepc",     12'h341, 32'h0000_3000);
      read_csr("irq_mstatus",  12'h300, 32'h0000_1880);

      // mcycle carry into the high word; the high-word write holds the low word.
      csr_op(3'b001, 12'hB00, 32'hFFFF_FFFF);
      csr_op(3'b001, 12'hB80, 32'h0000_0000);
      read_csr("mcycle_pre",  12'hB00, 32'hFFFF_FFFF);
      read_csr("mcycleh_pre", 12'hB80, 32'h0000_0000);
      step();
      read_csr("mcycle_wrap",  12'hB00, 32'h0000_0000);
      read_csr("mcycleh_carry", 12'hB80, 32'h0000_0001);
      read_csr("cycleh_shadow", 12'hC80, 32'h0000_0001);
      csr_op(3'b001, 12'hC00, 32'h0000_0055);
      read_csr("cycle_ro", 12'hC00, 32'h0000_0001);

      // minstret: write overrides increment, then full 64-bit wrap.
      instruction_retired = 1'b1;
      instruction_valid   = 1'b1;
      csr_write_enable    = 1'b1;
      function_3          = 3'b001;
      csr_address         = 12'hB02;
      csr_write_operand   = 32'd5;
      step();
      idle_inputs();
      read_csr("minstret_override", 12'hB02, 32'd5);
      instruction_retired = 1'b1;
      step();
      instruction_retired = 1'b0;
      read_csr("instret_inc", 12'hC02, 32'd6);
      step();
      read_csr("instret_hold", 12'hC02, 32'd6);
      csr_op(3'b001, 12'hB02, 32'hFFFF_FFFF);
      csr_op(3'b001, 12'hB82, 32'hFFFF_FFFF);
      read_csr("minstreth_all1", 12'hB82, 32'hFFFF_FFFF);
      instruction_retired = 1'b1;
      step();
      instruction_retired = 1'b0;
      read_csr("minstret_wrap_lo", 12'hB02, 32'h0);
      read_csr("minstret_wrap_hi", 12'hC82, 32'h0);

      // mtvec low bits are hardwired to zero and feed the trap target.
      csr_op(3'b001, 12'h305, 32'h0000_0203);
      read_csr("mtvec_align", 12'h305, 32'h0000_0200);
      instruction_valid   = 1'b1;
      is_environment_call = 1'b1;
      #1;
      check_value("mtvec_target", trap_target_pc, 32'h0000_0200);

      // Reset in the same cycle as an ECALL discards its update.
      reset = 1'b1;
      #1;
      check_value("reset_trap_gate", {31'd0, trap_taken}, 32'd0);
      step();
      idle_inputs();
      reset = 1'b0;
      read_csr("reset_mcause",   12'h342, 32'h0);
      read_csr("reset_mepc",     12'h341, 32'h0);
      read_csr("reset_mtvec",    12'h305, 32'h0000_0100);
      read_csr("reset_mscratch", 12'h340, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
